fifo_flag_ctrl: RTL

- Parametrised FIFO occupancy and status-flag controller.
- Owns the write and read pointers and an occupancy counter, and produces registered full, empty, almost-full and almost-empty flags.
- Almost-full and almost-empty thresholds are programmable at run time and have hysteresis.
- Sticky overflow and underflow error flags are provided; the block sits beside the FIFO RAM and drives its addresses.

---
 rtl/fifo_flag_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/fifo_flag_ctrl.sv
// FIFO occupancy/flag controller: owns the RAM pointers and the occupancy count, and
// produces registered full/empty/almost flags with programmable hysteretic thresholds.
module fifo_flag_ctrl #(
    parameter int ADDR_W  = 4,
    parameter int AF_INIT = 10,
    parameter int AE_INIT = 2,
    parameter int HYST    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              cfg_we,
    input  logic [ADDR_W:0]   cfg_af,
    input  logic [ADDR_W:0]   cfg_ae,
    input  logic              clr_err,
    output logic [ADDR_W-1:0] w_ptr,
    output logic [ADDR_W-1:0] r_ptr,
    output logic [ADDR_W:0]   count,
    output logic              wr_ack,
    output logic              rd_ack,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CW    = ADDR_W + 1;

    logic [CW-1:0] af_thr;
    logic [CW-1:0] ae_thr;
    logic [CW-1:0] cnt_n;

    // Set at cnt >= thr; release only once cnt drops below thr-HYST (floored at 0).
    function automatic logic af_eval(input logic [CW-1:0] cnt,
                                     input logic [CW-1:0] thr,
                                     input logic          cur);
        logic [CW:0] lo;
        lo = ({1'b0, thr} > (CW+1)'(HYST)) ? ({1'b0, thr} - (CW+1)'(HYST)) : '0;
        if (cnt >= thr)
            return 1'b1;
        if ({1'b0, cnt} < lo)
            return 1'b0;
        return cur;
    endfunction

    // Set at cnt <= thr; release only once cnt rises above thr+HYST (one extra bit, no wrap).
    function automatic logic ae_eval(input logic [CW-1:0] cnt,
                                     input logic [CW-1:0] thr,
                                     input logic          cur);
        logic [CW:0] hi;
        hi = {1'b0, thr} + (CW+1)'(HYST);
        if (cnt <= thr)
            return 1'b1;
        if ({1'b0, cnt} > hi)
            return 1'b0;
        return cur;
    endfunction

    // A read frees a slot in the same cycle, so a full FIFO still takes a paired write.
    assign rd_ack = rd_en & ~empty;
    assign wr_ack = wr_en & (~full | rd_ack);

    always_comb begin
        cnt_n = count;
        case ({wr_ack, rd_ack})
            2'b10:   cnt_n = count + CW'(1);
            2'b01:   cnt_n = count - CW'(1);
            default: cnt_n = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr        <= '0;
            r_ptr        <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            af_thr       <= CW'(AF_INIT);
            ae_thr       <= CW'(AE_INIT);
        end else begin
            if (wr_ack)
                w_ptr <= w_ptr + ADDR_W'(1);
            if (rd_ack)
                r_ptr <= r_ptr + ADDR_W'(1);
            count        <= cnt_n;
            full         <= (cnt_n == CW'(DEPTH));
            empty        <= (cnt_n == '0);
            // Flags on a cfg_we edge still see the old thresholds.
            almost_full  <= af_eval(cnt_n, af_thr, almost_full);
            almost_empty <= ae_eval(cnt_n, ae_thr, almost_empty);
            if (cfg_we) begin
                af_thr <= cfg_af;
                ae_thr <= cfg_ae;
            end
            overflow  <= (wr_en & ~wr_ack) | (overflow & ~clr_err);
            underflow <= (rd_en & ~rd_ack) | (underflow & ~clr_err);
        end
    end

endmodule
